i2s_rx_ctrl: RTL and testbench

Single-clock sequencer for the I2S slave receiver. It runs in the `WBs_CLK_i` domain.
- Enables and disables the receiver through `I2S_S_EN_o`.
- Pairs left and right samples into 32-bit stereo words and writes them to the RX FIFO.
- Counts words into software-sized blocks and raises a block interrupt.
- Detects I2S clock loss and FIFO overflow, and reports both as sticky status.

It sits between the Wishbone register block and the receiver/FIFO pair.

---
 rtl/i2s_rx_pkg.sv | 24 ++
 rtl/i2s_rx_blk_cnt.sv | 42 ++++
 rtl/i2s_rx_ctrl.sv | 134 +++++++++++++
 tb/tb_i2s_rx_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_rx_pkg.sv
// Shared types and constants for the I2S slave receive sequencer.
// The state encoding is visible to software via state_o, so the values are fixed.
package i2s_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_WAIT_L = 3'd2,
    ST_WAIT_R = 3'd3,
    ST_ERR    = 3'd4
  } rx_state_t;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned WORD_W   = 32;

  // Stereo word layout in the FIFO: left sample in the upper half.
  localparam bit PACK_LEFT_HIGH = 1'b1;

  function automatic logic [WORD_W-1:0] pack_word(input logic [SAMPLE_W-1:0] left,
                                                  input logic [SAMPLE_W-1:0] right);
    return PACK_LEFT_HIGH ? {left, right} : {right, left};
  endfunction

endpackage

// File: rtl/i2s_rx_blk_cnt.sv
// Block word counter: loads the block length at run start, counts FIFO writes,
// wraps at the block length and pulses blk_done alongside the completing write.
module i2s_rx_blk_cnt #(
  parameter int unsigned BLK_W = 9
) (
  input  logic             i2s_clk_int,
  input  logic             rst,
  input  logic             load,
  input  logic [BLK_W-1:0] len,
  input  logic             inc,
  output logic [BLK_W-1:0] cnt,
  output logic             blk_done
);

  logic [BLK_W-1:0] len_q;
  logic [BLK_W-1:0] cnt_inc;

  // A length of 0 means 2^BLK_W: the incremented count wraps to 0 and matches.
  assign cnt_inc = cnt + BLK_W'(1);

  always_ff @(posedge i2s_clk_int) begin
    if (rst) begin
      len_q    <= '0;
      cnt      <= '0;
      blk_done <= 1'b0;
    end else begin
      blk_done <= 1'b0;
      if (load) begin
        len_q <= len;
        cnt   <= '0;
      end else if (inc) begin
        if (cnt_inc == len_q) begin
          cnt      <= '0;
          blk_done <= 1'b1;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: rtl/i2s_rx_ctrl.sv
// I2S slave receive sequencer: enables the receiver, pairs L/R samples into
// 32-bit FIFO words, counts blocks and keeps sticky overflow / clock-loss status.
module i2s_rx_ctrl
  import i2s_rx_pkg::*;
#(
  parameter int unsigned BLK_W      = 9,
  parameter int unsigned SETTLE_CYC = 8
) (
  input  logic             WBs_CLK_i,
  input  logic             WBs_RST_i,
  input  logic             ctrl_en_i,
  input  logic [BLK_W-1:0] blk_len_i,
  input  logic             irq_clr_i,
  input  logic             push_left_i,
  input  logic             push_right_i,
  input  logic [15:0]      data_left_i,
  input  logic [15:0]      data_right_i,
  input  logic             i2s_dis_i,
  input  logic             fifo_full_i,
  output logic             I2S_S_EN_o,
  output logic             fifo_push_o,
  output logic [31:0]      fifo_wdata_o,
  output logic             blk_done_o,
  output logic             irq_o,
  output logic             ovfl_o,
  output logic             clk_lost_o,
  output logic [BLK_W-1:0] word_cnt_o,
  output logic [2:0]       state_o
);

  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

  rx_state_t     state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [15:0]   hold_q, hold_d;
  logic          wr_en;
  logic          ovfl_set;
  logic          lost_set;
  logic          cnt_load;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    hold_d   = hold_q;
    wr_en    = 1'b0;
    ovfl_set = 1'b0;
    lost_set = 1'b0;
    cnt_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_en_i) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
          cnt_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!ctrl_en_i) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else if (settle_q == SET_LAST) begin
          state_d = ST_WAIT_L;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      ST_WAIT_L, ST_WAIT_R: begin
        // Clock loss outranks a software stop; neither lets a pending pair through.
        if (i2s_dis_i) begin
          state_d  = ST_ERR;
          lost_set = 1'b1;
          hold_d   = '0;
        end else if (!ctrl_en_i) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else begin
          if (state_q == ST_WAIT_R && push_right_i) begin
            if (fifo_full_i) ovfl_set = 1'b1;
            else             wr_en    = 1'b1;
            state_d = ST_WAIT_L;
          end
          // A new left sample always wins the hold register and re-arms WAIT_R.
          if (push_left_i) begin
            hold_d  = data_left_i;
            state_d = ST_WAIT_R;
          end
        end
      end
      ST_ERR: begin
        if (!ctrl_en_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      state_q      <= ST_IDLE;
      settle_q     <= '0;
      hold_q       <= '0;
      fifo_push_o  <= 1'b0;
      fifo_wdata_o <= '0;
      irq_o        <= 1'b0;
      ovfl_o       <= 1'b0;
      clk_lost_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      hold_q      <= hold_d;
      fifo_push_o <= wr_en;
      if (wr_en) fifo_wdata_o <= pack_word(hold_q, data_right_i);
      irq_o      <= blk_done_o | (irq_o & ~irq_clr_i);
      ovfl_o     <= ovfl_set   | (ovfl_o & ~irq_clr_i);
      clk_lost_o <= lost_set   | (clk_lost_o & ~irq_clr_i);
    end
  end

  i2s_rx_blk_cnt #(
    .BLK_W (BLK_W)
  ) u_blk_cnt (
    .i2s_clk_int (WBs_CLK_i),
    .rst         (WBs_RST_i),
    .load        (cnt_load),
    .len         (blk_len_i),
    .inc         (wr_en),
    .cnt         (word_cnt_o),
    .blk_done    (blk_done_o)
  );

  assign I2S_S_EN_o = (state_q == ST_SETTLE) || (state_q == ST_WAIT_L) || (state_q == ST_WAIT_R);
  assign state_o    = state_q;

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Directed + randomized bench for i2s_rx_ctrl with a transaction-level expected-word queue.
module tb_i2s_rx_ctrl;

  localparam int unsigned BLK_W      = 9;
  localparam int unsigned SETTLE_CYC = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ctrl_en = 1'b0;
  logic [BLK_W-1:0] blk_len = '0;
  logic             irq_clr = 1'b0;
  logic             push_left = 1'b0;
  logic             push_right = 1'b0;
  logic [15:0]      data_left = '0;
  logic [15:0]      data_right = '0;
  logic             i2s_dis = 1'b0;
  logic             fifo_full = 1'b0;
  logic             I2S_S_EN_o;
  logic             fifo_push_o;
  logic [31:0]      fifo_wdata_o;
  logic             blk_done_o;
  logic             irq_o;
  logic             ovfl_o;
  logic             clk_lost_o;
  logic [BLK_W-1:0] word_cnt_o;
  logic [2:0]       state_o;

  i2s_rx_ctrl #(
    .BLK_W      (BLK_W),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .WBs_CLK_i    (clk),
    .WBs_RST_i    (rst),
    .ctrl_en_i    (ctrl_en),
    .blk_len_i    (blk_len),
    .irq_clr_i    (irq_clr),
    .push_left_i  (push_left),
    .push_right_i (push_right),
    .data_left_i  (data_left),
    .data_right_i (data_right),
    .i2s_dis_i    (i2s_dis),
    .fifo_full_i  (fifo_full),
    .I2S_S_EN_o   (I2S_S_EN_o),
    .fifo_push_o  (fifo_push_o),
    .fifo_wdata_o (fifo_wdata_o),
    .blk_done_o   (blk_done_o),
    .irq_o        (irq_o),
    .ovfl_o       (ovfl_o),
    .clk_lost_o   (clk_lost_o),
    .word_cnt_o   (word_cnt_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  int          m_acc     = 0;
  int          m_len_eff = 1;
  logic [31:0] mon_w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Every FIFO write must be the next expected word; block position follows from the write count.
  always @(posedge clk) begin
    #1;
    if (fifo_push_o) begin
      if (exp_q.size() == 0) begin
        chk("spurious_push", 64'(fifo_push_o), 64'd0);
      end else begin
        mon_w = exp_q.pop_front();
        m_acc++;
        chk("wdata", 64'(fifo_wdata_o), 64'(mon_w));
        chk("blk_done", 64'(blk_done_o), 64'((m_acc % m_len_eff) == 0));
        chk("word_cnt", 64'(word_cnt_o), 64'(m_acc % m_len_eff));
      end
    end else if (blk_done_o) begin
      chk("done_without_push", 64'(blk_done_o), 64'd0);
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_en"},    64'(I2S_S_EN_o),   64'd0);
    chk({tag, "_push"},  64'(fifo_push_o),  64'd0);
    chk({tag, "_wdata"}, 64'(fifo_wdata_o), 64'd0);
    chk({tag, "_done"},  64'(blk_done_o),   64'd0);
    chk({tag, "_irq"},   64'(irq_o),        64'd0);
    chk({tag, "_ovfl"},  64'(ovfl_o),       64'd0);
    chk({tag, "_lost"},  64'(clk_lost_o),   64'd0);
    chk({tag, "_cnt"},   64'(word_cnt_o),   64'd0);
    chk({tag, "_state"}, 64'(state_o),      64'd0);
  endtask

  task automatic start_run(input logic [BLK_W-1:0] len, input int dis_at);
    blk_len = len;
    ctrl_en = 1'b1;
    tick();
    m_acc     = 0;
    m_len_eff = (len == 0) ? (1 << BLK_W) : int'(len);
    chk("settle_state", 64'(state_o), 64'd1);
    chk("settle_en", 64'(I2S_S_EN_o), 64'd1);
    chk("settle_cnt_clear", 64'(word_cnt_o), 64'd0);
    for (int k = 1; k <= int'(SETTLE_CYC); k++) begin
      i2s_dis = (k == dis_at);
      tick();
    end
    i2s_dis = 1'b0;
    chk("run_state", 64'(state_o), 64'd2);
  endtask

  task automatic send_left(input logic [15:0] d);
    push_left = 1'b1;
    data_left = d;
    tick();
    push_left = 1'b0;
    data_left = 16'($urandom);
  endtask

  task automatic pair(input logic [15:0] l, input logic [15:0] r, input bit full, input bit clr);
    send_left(l);
    tick($urandom_range(2));
    if (!full) exp_q.push_back({l, r});
    push_right = 1'b1;
    data_right = r;
    fifo_full  = full;
    irq_clr    = clr;
    tick();
    push_right = 1'b0;
    fifo_full  = 1'b0;
    irq_clr    = 1'b0;
    data_right = 16'($urandom);
    if (full) chk("ovfl_set", 64'(ovfl_o), 64'd1);
  endtask

  task automatic clear_status();
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
  endtask

  initial begin
    int  acc;
    bit  f;

    // Reset values
    tick(2);
    chk_reset("reset");
    rst = 1'b0;
    tick();

    // Normal run, block of 4, eight pairs
    start_run(BLK_W'(4), 0);
    for (int i = 1; i <= 8; i++) begin
      pair(16'h1000 + 16'(i), 16'h2000 + 16'(i), 1'b0, 1'b0);
      if (i == 3) chk("irq_before_block", 64'(irq_o), 64'd0);
      if (i == 4) begin
        chk("irq_not_same_cycle", 64'(irq_o), 64'd0);
        tick();
        chk("irq_after_block", 64'(irq_o), 64'd1);
      end
    end
    tick();
    chk("irq_held", 64'(irq_o), 64'd1);
    clear_status();
    chk("irq_cleared", 64'(irq_o), 64'd0);

    // Overflow on pair 3 of 5, then set-wins-over-clear
    ctrl_en = 1'b0;
    tick();
    chk("idle_state", 64'(state_o), 64'd0);
    start_run(BLK_W'(8), 0);
    for (int i = 1; i <= 5; i++) begin
      pair(16'h3000 + 16'(i), 16'h4000 + 16'(i), (i == 3), 1'b0);
      if (i == 2) chk("ovfl_before", 64'(ovfl_o), 64'd0);
      if (i == 3) chk("cnt_after_drop", 64'(word_cnt_o), 64'd2);
    end
    chk("cnt_after_five", 64'(word_cnt_o), 64'd4);
    pair(16'h5555, 16'h6666, 1'b1, 1'b1);
    clear_status();
    chk("ovfl_cleared", 64'(ovfl_o), 64'd0);

    // Right first is ignored, later left overwrites the hold
    push_right = 1'b1;
    data_right = 16'h1234;
    tick();
    push_right = 1'b0;
    chk("right_ignored_state", 64'(state_o), 64'd2);
    send_left(16'hAAAA);
    send_left(16'hBBBB);
    chk("left_overwrite_state", 64'(state_o), 64'd3);
    exp_q.push_back(32'hBBBBCCCC);
    push_right = 1'b1;
    data_right = 16'hCCCC;
    tick();
    push_right = 1'b0;
    chk("after_pair_state", 64'(state_o), 64'd2);

    // Simultaneous strobes complete the pair and start the next one
    send_left(16'h5555);
    exp_q.push_back(32'h55557777);
    push_left  = 1'b1;
    data_left  = 16'h6666;
    push_right = 1'b1;
    data_right = 16'h7777;
    tick();
    push_left  = 1'b0;
    push_right = 1'b0;
    chk("both_strobes_state", 64'(state_o), 64'd3);
    exp_q.push_back(32'h66668888);
    push_right = 1'b1;
    data_right = 16'h8888;
    tick();
    push_right = 1'b0;
    chk("after_both_state", 64'(state_o), 64'd2);

    // Clock loss: masked during settle, honoured in WAIT_R
    ctrl_en = 1'b0;
    tick();
    clear_status();
    start_run(BLK_W'(4), 3);
    chk("lost_masked", 64'(clk_lost_o), 64'd0);
    send_left(16'h1111);
    i2s_dis = 1'b1;
    tick();
    chk("err_state", 64'(state_o), 64'd4);
    chk("err_en", 64'(I2S_S_EN_o), 64'd0);
    chk("lost_set", 64'(clk_lost_o), 64'd1);
    tick();
    chk("err_holds", 64'(state_o), 64'd4);
    ctrl_en = 1'b0;
    i2s_dis = 1'b0;
    tick();
    chk("err_to_idle", 64'(state_o), 64'd0);
    chk("lost_sticky", 64'(clk_lost_o), 64'd1);
    clear_status();
    chk("lost_cleared", 64'(clk_lost_o), 64'd0);

    // Mask edge: last settle cycle ignored, first WAIT_L cycle honoured
    start_run(BLK_W'(4), int'(SETTLE_CYC));
    i2s_dis = 1'b1;
    tick();
    chk("mask_edge_err", 64'(state_o), 64'd4);
    ctrl_en = 1'b0;
    i2s_dis = 1'b0;
    tick();
    clear_status();

    // Stop in WAIT_R discards the partial word; re-enable clears the count
    start_run(BLK_W'(4), 0);
    pair(16'h0101, 16'h0202, 1'b0, 1'b0);
    send_left(16'hDEAD);
    ctrl_en = 1'b0;
    tick();
    chk("stop_idle", 64'(state_o), 64'd0);
    chk("stop_en", 64'(I2S_S_EN_o), 64'd0);
    tick(2);
    start_run(BLK_W'(4), 0);

    // Reset mid-block with irq pending
    ctrl_en = 1'b0;
    tick();
    start_run(BLK_W'(2), 0);
    pair(16'h7001, 16'h8001, 1'b0, 1'b0);
    pair(16'h7002, 16'h8002, 1'b0, 1'b0);
    pair(16'h7003, 16'h8003, 1'b0, 1'b0);
    send_left(16'h7004);
    chk("irq_pre_reset", 64'(irq_o), 64'd1);
    rst     = 1'b1;
    ctrl_en = 1'b0;
    tick();
    chk_reset("midrst");
    rst = 1'b0;
    tick();

    // Random stream, blk_len 0 (full 2^BLK_W block), length change mid-run ignored
    start_run('0, 0);
    blk_len = BLK_W'(3);
    acc = 0;
    while (acc < 515) begin
      f = ($urandom_range(7) == 0);
      pair(16'($urandom), 16'($urandom), f, 1'b0);
      if (!f) acc++;
      tick($urandom_range(1));
    end
    tick();
    chk("irq_full_block", 64'(irq_o), 64'd1);
    chk("cnt_after_wrap", 64'(word_cnt_o), 64'd3);

    ctrl_en = 1'b0;
    tick(3);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
